// File: rtl/irq_pkg.sv
// Shared constants and FSM encoding for the interrupt collector.
package irq_pkg;

    localparam int unsigned NUM_SRC_DEF   = 8;
    localparam int unsigned ID_W_DEF      = 3;
    localparam int unsigned TIMER_IRQ_IDX = 0;

    typedef logic [1:0] irq_state_t;

    localparam irq_state_t ST_IDLE = 2'd0;
    localparam irq_state_t ST_REQ  = 2'd1;
    localparam irq_state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/irq_collector_if.sv
// Source/enable/CPU-ack bundle between the interrupt collector and its neighbours.
interface irq_collector_if #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
);

    logic [NUM_SRC-1:0] irq_src;
    logic               en_wr;
    logic [NUM_SRC-1:0] en_wdata;
    logic               irq_ack;
    logic               irq_req;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] irq_en;
    logic [NUM_SRC-1:0] irq_pend;

    modport master (
        output irq_src, en_wr, en_wdata, irq_ack,
        input  irq_req, irq_id, irq_en, irq_pend
    );

    modport slave (
        input  irq_src, en_wr, en_wdata, irq_ack,
        output irq_req, irq_id, irq_en, irq_pend
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder; index is zero-extended to ID_W.
module irq_prio_enc import irq_pkg::*; #(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic [NUM_SRC-1:0] elig_i,
    output logic               any_valid_o,
    output logic [ID_W-1:0]    idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any_valid_o = |elig_i;
        idx_o       = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_collector.sv
// Interrupt collector: edge-detects level sources, latches pending, gates with enables
// and presents one request/ID to the CPU until acked. IRQ_SYNC2_EN adds a 2-flop input synchronizer.
module irq_collector import irq_pkg::*; #(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    irq_collector_if.slave bus
);

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    irq_state_t         state_q, state_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               enc_any;
    logic [ID_W-1:0]    enc_idx;

`ifdef IRQ_SYNC2_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for sources from foreign clock domains.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = bus.irq_src;
`endif

    assign rise   = src_s & ~src_q;
    assign elig   = pend_q & en_q;
    assign en_d   = bus.en_wr ? bus.en_wdata : en_q;
    // A new edge on the bit being acked survives the clear.
    assign pend_d = (pend_q & ~clr) | rise;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .elig_i      (elig),
        .any_valid_o (enc_any),
        .idx_o       (enc_idx)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            src_q   <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            src_q   <= src_s;
            pend_q  <= pend_d;
            en_q    <= en_d;
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
        end
    end

    // Request FSM: the ID is frozen for the whole REQ phase; GAP forces one idle cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    id_d    = enc_idx;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    clr     = NUM_SRC'(1) << id_q;
                    req_d   = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.irq_req  = req_q;
    assign bus.irq_id   = id_q;
    assign bus.irq_en   = en_q;
    assign bus.irq_pend = pend_q;

endmodule

// File: tb/tb_irq_collector.sv
// Self-checking bench for irq_collector: directed scenarios plus randomized traffic
// against a cycle-level reference model. Honours IRQ_SYNC2_EN.
module tb_irq_collector;
    import irq_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
`ifdef IRQ_SYNC2_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 sys_clk = ~sys_clk;

    irq_collector_if #(.NUM_SRC(N), .ID_W(IW)) bus ();

    irq_collector #(.NUM_SRC(N), .ID_W(IW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Reference model state
    logic [N-1:0]  m_prev, m_s1, m_s2, m_pend, m_en;
    logic          m_req, m_gap;
    logic [IW-1:0] m_id;

    task automatic model_reset();
        m_prev = '0; m_s1 = '0; m_s2 = '0; m_pend = '0; m_en = '0;
        m_req = 1'b0; m_gap = 1'b0; m_id = '0;
    endtask

    function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
        logic [N-1:0] lsb;
        int k;
        lsb = v & (~v + N'(1));
        k = 0;
        while (lsb > N'(1)) begin
            lsb = lsb >> 1;
            k++;
        end
        return IW'(k);
    endfunction

    task automatic model_edge();
        logic [N-1:0] seen, rise, clr, elig;
        if (sys_rst) begin
            model_reset();
        end else begin
            seen = (SYNC_LAT != 0) ? m_s2 : bus.irq_src;
            rise = seen & ~m_prev;
            clr  = (m_req && bus.irq_ack) ? (N'(1) << m_id) : '0;
            elig = m_pend & m_en;
            if (m_req) begin
                if (bus.irq_ack) begin
                    m_req = 1'b0;
                    m_gap = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (elig != '0) begin
                m_id  = lowest(elig);
                m_req = 1'b1;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (bus.en_wr) m_en = bus.en_wdata;
            m_s2   = m_s1;
            m_s1   = bus.irq_src;
            m_prev = seen;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        sys_rst      = 1'b1;
        model_reset();
        bus.irq_src  = '0;
        bus.en_wr    = 1'b0;
        bus.en_wdata = '0;
        bus.irq_ack  = 1'b0;
        repeat (2) tick();
        #2 sys_rst = 1'b0;
    endtask

    task automatic write_en(input logic [N-1:0] v);
        bus.en_wr    = 1'b1;
        bus.en_wdata = v;
        tick();
        bus.en_wr    = 1'b0;
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.irq_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.irq_req); end
        total++; if (bus.irq_id !== 3'd0) begin bad++; $display("FAIL rst_id: got %0d want 0", bus.irq_id); end
        total++; if (bus.irq_en !== 8'h00) begin bad++; $display("FAIL rst_en: got %h want 00", bus.irq_en); end
        total++; if (bus.irq_pend !== 8'h00) begin bad++; $display("FAIL rst_pend: got %h want 00", bus.irq_pend); end
    endtask

    task automatic test_timer_basic();
        write_en(8'h01);
        total++; if (bus.irq_en !== 8'h01) begin bad++; $display("FAIL tmr_en: got %h want 01", bus.irq_en); end
        repeat (3) tick();
        bus.irq_src = N'(1) << TIMER_IRQ_IDX;
        repeat (SYNC_LAT) tick();
        tick();
        total++; if (bus.irq_pend !== 8'h01 || bus.irq_req !== 1'b0) begin
            bad++; $display("FAIL tmr_pend: got pend=%h req=%b want pend=01 req=0", bus.irq_pend, bus.irq_req);
        end
        tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd0) begin
            bad++; $display("FAIL tmr_req: got req=%b id=%0d want req=1 id=0", bus.irq_req, bus.irq_id);
        end
        repeat (2) tick();
        total++; if (bus.irq_req !== 1'b1) begin bad++; $display("FAIL tmr_hold: got req=%b want 1", bus.irq_req); end
        do_ack();
        total++; if (bus.irq_req !== 1'b0 || bus.irq_pend !== 8'h00) begin
            bad++; $display("FAIL tmr_ack: got req=%b pend=%h want req=0 pend=00", bus.irq_req, bus.irq_pend);
        end
        repeat (3) tick();
        total++; if (bus.irq_req !== 1'b0) begin bad++; $display("FAIL tmr_level: got req=%b want 0", bus.irq_req); end
        bus.irq_src = '0;
        repeat (3) tick();
    endtask

    task automatic test_priority();
        write_en(8'hFF);
        bus.irq_src = 8'h24;
        repeat (SYNC_LAT + 2) tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd2 || bus.irq_pend !== 8'h24) begin
            bad++; $display("FAIL pri_first: got req=%b id=%0d pend=%h want 1/2/24", bus.irq_req, bus.irq_id, bus.irq_pend);
        end
        do_ack();
        total++; if (bus.irq_req !== 1'b0 || bus.irq_pend !== 8'h20) begin
            bad++; $display("FAIL pri_gap: got req=%b pend=%h want 0/20", bus.irq_req, bus.irq_pend);
        end
        tick();
        total++; if (bus.irq_req !== 1'b0) begin bad++; $display("FAIL pri_idle: got req=%b want 0", bus.irq_req); end
        tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd5) begin
            bad++; $display("FAIL pri_second: got req=%b id=%0d want 1/5", bus.irq_req, bus.irq_id);
        end
        // Higher-priority arrival must not change the outstanding request.
        bus.irq_src = 8'h25;
        repeat (SYNC_LAT + 2) tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd5 || bus.irq_pend !== 8'h21) begin
            bad++; $display("FAIL pri_sticky: got req=%b id=%0d pend=%h want 1/5/21", bus.irq_req, bus.irq_id, bus.irq_pend);
        end
        do_ack();
        repeat (2) tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd0) begin
            bad++; $display("FAIL pri_third: got req=%b id=%0d want 1/0", bus.irq_req, bus.irq_id);
        end
        do_ack();
        total++; if (bus.irq_pend !== 8'h00) begin bad++; $display("FAIL pri_drain: got pend=%h want 00", bus.irq_pend); end
        bus.irq_src = '0;
        repeat (3) tick();
    endtask

    task automatic test_disabled_pending();
        write_en(8'h00);
        bus.irq_src = 8'h08;
        repeat (SYNC_LAT + 1) tick();
        total++; if (bus.irq_pend !== 8'h08) begin bad++; $display("FAIL dis_pend: got %h want 08", bus.irq_pend); end
        repeat (3) tick();
        total++; if (bus.irq_req !== 1'b0) begin bad++; $display("FAIL dis_noreq: got req=%b want 0", bus.irq_req); end
        write_en(8'h08);
        total++; if (bus.irq_en !== 8'h08 || bus.irq_req !== 1'b0) begin
            bad++; $display("FAIL dis_enw: got en=%h req=%b want 08/0", bus.irq_en, bus.irq_req);
        end
        tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin
            bad++; $display("FAIL dis_req: got req=%b id=%0d want 1/3", bus.irq_req, bus.irq_id);
        end
    endtask

    task automatic test_set_beats_clear();
        bus.irq_src = 8'h00;
        tick();
        bus.irq_src = 8'h08;
        repeat (SYNC_LAT) tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin
            bad++; $display("FAIL sbc_held: got req=%b id=%0d want 1/3", bus.irq_req, bus.irq_id);
        end
        do_ack();
        total++; if (bus.irq_req !== 1'b0 || bus.irq_pend !== 8'h08) begin
            bad++; $display("FAIL sbc_pend: got req=%b pend=%h want 0/08", bus.irq_req, bus.irq_pend);
        end
        tick();
        total++; if (bus.irq_req !== 1'b0) begin bad++; $display("FAIL sbc_idle: got req=%b want 0", bus.irq_req); end
        tick();
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin
            bad++; $display("FAIL sbc_rereq: got req=%b id=%0d want 1/3", bus.irq_req, bus.irq_id);
        end
        do_ack();
        bus.irq_src = '0;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        write_en(8'h01);
        bus.irq_src = 8'h01;
        repeat (SYNC_LAT + 2) tick();
        total++; if (bus.irq_req !== 1'b1) begin bad++; $display("FAIL ar_pre: got req=%b want 1", bus.irq_req); end
        #2 sys_rst = 1'b1;
        model_reset();
        #1;
        total++; if (bus.irq_req !== 1'b0 || bus.irq_pend !== 8'h00 || bus.irq_en !== 8'h00) begin
            bad++; $display("FAIL ar_async: got req=%b pend=%h en=%h want 0/00/00", bus.irq_req, bus.irq_pend, bus.irq_en);
        end
        bus.irq_src = '0;
        repeat (2) tick();
        #1 sys_rst = 1'b0;
        write_en(8'h01);
        bus.irq_ack = 1'b1;
        repeat (2) tick();
        bus.irq_ack = 1'b0;
        total++; if (bus.irq_req !== 1'b0 || bus.irq_pend !== 8'h00 || bus.irq_id !== 3'd0 || bus.irq_en !== 8'h01) begin
            bad++; $display("FAIL ar_idle_ack: got req=%b pend=%h id=%0d en=%h want 0/00/0/01",
                            bus.irq_req, bus.irq_pend, bus.irq_id, bus.irq_en);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) bus.irq_src = bus.irq_src ^ (N'(1) << $urandom_range(N - 1));
            bus.en_wr    = ($urandom_range(7) == 0);
            bus.en_wdata = N'($urandom);
            bus.irq_ack  = ($urandom_range(2) == 0);
            tick();
            total++; if (bus.irq_req !== m_req) begin
                bad++; $display("FAIL rnd_req c=%0d: got %b want %b", c, bus.irq_req, m_req);
            end
            total++; if (bus.irq_id !== m_id) begin
                bad++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, bus.irq_id, m_id);
            end
            total++; if (bus.irq_pend !== m_pend) begin
                bad++; $display("FAIL rnd_pend c=%0d: got %h want %h", c, bus.irq_pend, m_pend);
            end
            total++; if (bus.irq_en !== m_en) begin
                bad++; $display("FAIL rnd_en c=%0d: got %h want %h", c, bus.irq_en, m_en);
            end
        end
        bus.en_wr   = 1'b0;
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_timer_basic();
        test_priority();
        test_disabled_pending();
        test_set_beats_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
